// File: rtl/piso_frame_sequencer.sv
// Frame sequencer feeding a PISO serializer: captures a frame of band words and
// walks them out as load/shift steps, with an optional idle gap between frames.
module piso_frame_sequencer #(
  parameter int unsigned N_BANDS    = 8,
  parameter int unsigned WORD_W     = 3,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned BandW     = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BANDS*WORD_W-1:0] bands_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WORD_W-1:0]         parallel_out,
  output logic                      sl,
  output logic                      frame_start,
  output logic [BandW-1:0]          band_idx,
  output logic                      busy
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BandW-1:0] LastBand = BandW'(N_BANDS - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'((WORD_W > 1) ? WORD_W - 2 : 0);
  localparam logic [GapW-1:0]  LastGap  = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e                    state;
  logic [N_BANDS*WORD_W-1:0] snapshot;
  logic [BandW-1:0]          band;
  logic [BitW-1:0]           bit_cnt;
  logic [GapW-1:0]           gap_cnt;
  logic                      word_done;

  function automatic logic [WORD_W-1:0] word_of(input logic [N_BANDS*WORD_W-1:0] f,
                                                input logic [BandW-1:0] b);
    return f[b*WORD_W +: WORD_W];
  endfunction

  // Last cycle of the current word: the load itself when there is nothing to shift.
  assign word_done = (state == StLoad && WORD_W == 1) ||
                     (state == StShift && bit_cnt == LastBit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      snapshot     <= '0;
      band         <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      parallel_out <= '0;
      sl           <= 1'b0;
      frame_start  <= 1'b0;
      band_idx     <= '0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            snapshot     <= bands_in;
            band         <= '0;
            state        <= StLoad;
            sl           <= 1'b1;
            parallel_out <= word_of(bands_in, '0);
            frame_start  <= 1'b1;
            band_idx     <= '0;
            busy         <= 1'b1;
            in_ready     <= 1'b0;
          end
        end
        StLoad: begin
          state       <= StShift;
          bit_cnt     <= '0;
          sl          <= 1'b0;
          frame_start <= 1'b0;
        end
        StShift: bit_cnt <= bit_cnt + 1'b1;
        StGap: begin
          if (gap_cnt == LastGap) begin
            state    <= StIdle;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase

      // Overrides the per-state updates above when the current word is finished.
      if (word_done) begin
        if (band != LastBand) begin
          band         <= band + 1'b1;
          band_idx     <= band + 1'b1;
          state        <= StLoad;
          sl           <= 1'b1;
          parallel_out <= word_of(snapshot, band + 1'b1);
        end else begin
          band         <= '0;
          band_idx     <= '0;
          sl           <= 1'b0;
          parallel_out <= '0;
          gap_cnt      <= '0;
          if (GAP_CYCLES > 0) begin
            state <= StGap;
          end else begin
            state    <= StIdle;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_sequencer.sv
// Bench for piso_frame_sequencer: timeline model plus PISO/scoreboard, with
// directed literal checks and extra instances for the degenerate parameter sets.
module tb_piso_frame_sequencer;
  localparam int N = 8;
  localparam int W = 3;
  localparam int G = 2;
  localparam int Busy = N * W + G;  // last busy cycle index after a capture

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] bands_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready, sl, frame_start, busy;
  logic [W-1:0]   parallel_out;
  logic [2:0]     band_idx;

  piso_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bands_in(bands_in), .in_valid(in_valid),
    .in_ready(in_ready), .parallel_out(parallel_out), .sl(sl),
    .frame_start(frame_start), .band_idx(band_idx), .busy(busy)
  );

  // N_BANDS=1, GAP_CYCLES=0 instance
  logic [2:0] n1_bands = '0;
  logic       n1_valid = 1'b0;
  logic       n1_ready, n1_sl, n1_fs, n1_busy;
  logic [2:0] n1_pw;
  logic [0:0] n1_idx;
  piso_frame_sequencer #(.N_BANDS(1), .WORD_W(3), .GAP_CYCLES(0)) u_n1 (
    .clk(clk), .rst_n(rst_n), .bands_in(n1_bands), .in_valid(n1_valid),
    .in_ready(n1_ready), .parallel_out(n1_pw), .sl(n1_sl),
    .frame_start(n1_fs), .band_idx(n1_idx), .busy(n1_busy)
  );

  // WORD_W=1 instance
  logic [7:0] w1_bands = '0;
  logic       w1_valid = 1'b0;
  logic       w1_ready, w1_sl, w1_fs, w1_busy;
  logic [0:0] w1_pw;
  logic [2:0] w1_idx;
  piso_frame_sequencer #(.N_BANDS(8), .WORD_W(1), .GAP_CYCLES(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .bands_in(w1_bands), .in_valid(w1_valid),
    .in_ready(w1_ready), .parallel_out(w1_pw), .sl(w1_sl),
    .frame_start(w1_fs), .band_idx(w1_idx), .busy(w1_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the capture edge, 0 when idle.
  int           k = 0;
  logic [N*W-1:0] m_frame = '0;
  logic [W-1:0] exp_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      exp_q.delete();
    end else if (k == 0) begin
      if (in_valid) begin
        k <= 1;
        m_frame <= bands_in;
        for (int b = 0; b < N; b++) exp_q.push_back(bands_in[b*W +: W]);
      end
    end else begin
      k <= (k == Busy) ? 0 : k + 1;
    end
  end

  function automatic logic [9:0] exp_out(input int kk, input logic [N*W-1:0] f);
    logic rdy, bsy, s, fs;
    logic [2:0] idx, pw;
    int b, p;
    rdy = 0; bsy = 0; s = 0; fs = 0; idx = 0; pw = 0;
    if (kk == 0) rdy = 1;
    else begin
      bsy = 1;
      if (kk <= N * W) begin
        b   = (kk - 1) / W;
        p   = (kk - 1) % W;
        s   = (p == 0);
        fs  = (kk == 1);
        idx = 3'(b);
        pw  = f[b*W +: W];
      end
    end
    return {rdy, bsy, s, fs, idx, pw};
  endfunction

  // Downstream PISO, LSB-first
  logic [W-1:0] sr;
  logic         serial;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else if (sl) sr <= parallel_out;
    else sr <= sr >> 1;
  end
  assign serial = sr[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           dut_acc[$];
  int           prev_k = 0;
  logic [W-1:0] acc = '0;
  always @(negedge clk) begin
    int p;
    check("cycle outputs", {in_ready, busy, sl, frame_start, band_idx, parallel_out},
          exp_out(k, m_frame));
    if (prev_k >= 1 && prev_k <= N * W) begin
      p = (prev_k - 1) % W;
      acc[p] = serial;
      if (p == W - 1) begin
        if (exp_q.size() == 0) check("scoreboard underflow", 1, 0);
        else check("deserialized word", acc, exp_q.pop_front());
      end
    end
    prev_k = k;
    if (in_ready && in_valid) dut_acc.push_back(cyc + 1);
  end

  task automatic wait_accept(input int n);
    int t = 0;
    while (dut_acc.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("accept within budget", dut_acc.size() >= n, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (k != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [23:0] sl_v, ser_v, pw_v;
  logic [8:0]  w1_sl_v;
  logic [2:0]  n1_sl_v;
  logic [3:0]  n1_rdy_v;
  int          ready_at, fs_cnt, n;

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single frame, bands 0..7
    @(posedge clk); #1;
    bands_in = 24'hFAC688;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    sl_v = '0; ser_v = '0; ready_at = 0; fs_cnt = 0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      if (i <= 24) sl_v = {sl_v[22:0], sl};
      if (i >= 2 && i <= 25) ser_v = {ser_v[22:0], serial};
      if (in_ready && ready_at == 0) ready_at = i;
      fs_cnt += int'(frame_start);
    end
    check("sl pattern", sl_v, 24'h924924);
    check("serial stream", ser_v, 24'h11635F);
    check("in_ready return cycle", ready_at, 27);
    check("frame_start count", fs_cnt, 1);

    // Reset mid-SHIFT of band 3
    @(posedge clk); #1;
    bands_in = 24'h5A3C96;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("band 3 shifting", {band_idx, sl}, {3'd3, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {in_ready, busy, sl, frame_start, band_idx, parallel_out},
          10'b10_0000_0000);
    @(posedge clk); #1 rst_n = 1'b1;
    fs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      fs_cnt += int'(busy) + int'(!in_ready);
    end
    check("no resumed frame", fs_cnt, 0);

    // Back-to-back with in_valid held
    @(posedge clk); #1;
    n = dut_acc.size();
    bands_in = 24'h123456;
    in_valid = 1'b1;
    @(posedge clk); #1;
    bands_in = 24'hABCDEF;
    wait_accept(n + 2);
    check("back-to-back interval", dut_acc[n+1] - dut_acc[n], 27);
    wait_idle();

    // Changes while busy are ignored
    n = dut_acc.size();
    bands_in = 24'h0F1E2D;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bands_in = {8{3'd7}};
    in_valid = 1'b1;
    wait_accept(n + 2);
    check("busy-ignore interval", dut_acc[n+1] - dut_acc[n], 27);
    wait_idle();

    // N_BANDS=1, GAP_CYCLES=0
    n1_bands = 3'd5;
    n1_valid = 1'b1;
    @(posedge clk); #1 n1_valid = 1'b0;
    n1_sl_v = '0; n1_rdy_v = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i <= 3) n1_sl_v = {n1_sl_v[1:0], n1_sl};
      n1_rdy_v = {n1_rdy_v[2:0], n1_ready};
      if (i == 1) check("n1 word and frame_start", {n1_pw, n1_fs}, {3'd5, 1'b1});
    end
    check("n1 sl pattern", n1_sl_v, 3'b100);
    check("n1 in_ready pattern", n1_rdy_v, 4'b0001);

    // WORD_W=1
    @(posedge clk); #1;
    w1_bands = 8'b1011_0010;
    w1_valid = 1'b1;
    @(posedge clk); #1 w1_valid = 1'b0;
    w1_sl_v = '0; pw_v = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      w1_sl_v = {w1_sl_v[7:0], w1_sl};
      if (i <= 8) pw_v = {pw_v[22:0], w1_idx};
      if (i <= 8) ser_v = {ser_v[22:0], w1_pw};
    end
    check("w1 sl pattern", w1_sl_v, 9'b111111110);
    check("w1 band_idx walk", pw_v, 24'h053977);
    check("w1 words", ser_v[7:0], 8'b0100_1101);

    // Random frames with random in_valid gaps
    for (int f = 0; f < 200; f++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      n = dut_acc.size();
      bands_in = {$urandom, $urandom} & 24'hFFFFFF;
      in_valid = 1'b1;
      wait_accept(n + 1);
    end
    wait_idle();
    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
